ccff_chain_loader: RTL and testbench

//  Synthesizable configuration-chain driver for the FPGA fabric.
//  - PROGRAM mode: streams a bitstream into NUM_CHAINS parallel ccff chains.
//  - CHECK mode: runs the single-pulse integrity test on every chain and

---
 rtl/ccff_chain_loader_if.sv | 13 +
 rtl/ccff_chain_loader.sv | 166 ++++++++++++++++
 tb/tb_ccff_chain_loader.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ccff_chain_loader_if.sv
// Word-stream handshake between the SoC bitstream source and the chain loader.
// One word carries WORD_WIDTH bits for each of NUM_CHAINS chains.
interface ccff_chain_loader_if #(
    parameter int unsigned NUM_CHAINS = 1,
    parameter int unsigned WORD_WIDTH = 32
);
    logic [NUM_CHAINS*WORD_WIDTH-1:0] in_data;
    logic                             in_valid;
    logic                             in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/ccff_chain_loader.sv
// Configuration-chain driver: streams a bitstream into parallel ccff chains (PROGRAM)
// or runs a single-pulse integrity test on every chain (CHECK).
module ccff_chain_loader #(
    parameter int unsigned NUM_CHAINS   = 1,
    parameter int unsigned CHAIN_LENGTH = 29696,
    parameter int unsigned WORD_WIDTH   = 32,
    parameter int unsigned CHECK_DEPTH  = 3
) (
    input  logic                   prog_clk,
    input  logic                   pReset,
    input  logic                   start,
    input  logic                   mode,
    input  logic                   abort,
    ccff_chain_loader_if.slave     word_bus,
    output logic [NUM_CHAINS-1:0]  ccff_head,
    input  logic [NUM_CHAINS-1:0]  ccff_tail,
    output logic                   shift_en,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_CHAINS-1:0]  err_chain
);

    localparam int unsigned CntW  = $clog2(CHAIN_LENGTH + CHECK_DEPTH + 1);
    localparam int unsigned BitW  = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam int unsigned DataW = NUM_CHAINS * WORD_WIDTH;

    localparam logic [CntW-1:0] LastShift = CntW'(CHAIN_LENGTH - 1);
    localparam logic [CntW-1:0] TailAt    = CntW'(CHAIN_LENGTH);
    localparam logic [CntW-1:0] LastCheck = CntW'(CHAIN_LENGTH + CHECK_DEPTH - 1);
    localparam logic [BitW-1:0] LastBit   = BitW'(WORD_WIDTH - 1);

    typedef enum logic [2:0] {StIdle, StLoad, StShift, StCheck, StDone} state_e;

    state_e                state_q, state_d;
    logic [DataW-1:0]      sreg_q, sreg_d;
    logic                  sreg_valid_q, sreg_valid_d;
    logic [DataW-1:0]      buf_q, buf_d;
    logic                  buf_full_q, buf_full_d;
    logic [BitW-1:0]       bit_idx_q, bit_idx_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [NUM_CHAINS-1:0] err_q, err_d;

    logic accept;
    logic shifting;
    logic sreg_free;
    logic exp_tail;

    assign busy      = (state_q == StLoad) || (state_q == StShift) || (state_q == StCheck);
    assign done      = (state_q == StDone);
    assign err_chain = err_q;

    always_comb begin
        state_d           = state_q;
        sreg_d            = sreg_q;
        sreg_valid_d      = sreg_valid_q;
        buf_d             = buf_q;
        buf_full_d        = buf_full_q;
        bit_idx_d         = bit_idx_q;
        cnt_d             = cnt_q;
        err_d             = err_q;
        shift_en          = 1'b0;
        ccff_head         = '0;
        word_bus.in_ready = 1'b0;
        accept            = 1'b0;
        shifting          = 1'b0;
        sreg_free         = 1'b0;
        exp_tail          = (cnt_q == TailAt);

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    err_d     = '0;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = mode ? StCheck : StLoad;
                end
            end
            StLoad, StShift: begin
                word_bus.in_ready = !buf_full_q;
                accept            = word_bus.in_valid && !buf_full_q;
                shifting          = (state_q == StShift) && sreg_valid_q;
                if (shifting) begin
                    shift_en = 1'b1;
                    for (int unsigned c = 0; c < NUM_CHAINS; c++) begin
                        ccff_head[c]                   = sreg_q[c*WORD_WIDTH + WORD_WIDTH - 1];
                        sreg_d[c*WORD_WIDTH +: WORD_WIDTH] = sreg_q[c*WORD_WIDTH +: WORD_WIDTH] << 1;
                    end
                    bit_idx_d = bit_idx_q + BitW'(1);
                    cnt_d     = cnt_q + CntW'(1);
                end
                // Shift register refills on the edge its last bit leaves, so words chain gaplessly.
                sreg_free = !sreg_valid_q || (shifting && (bit_idx_q == LastBit));
                if (sreg_free) begin
                    if (buf_full_q) begin
                        sreg_d       = buf_q;
                        sreg_valid_d = 1'b1;
                        bit_idx_d    = '0;
                        buf_full_d   = accept;
                        if (accept) buf_d = word_bus.in_data;
                    end else if (accept) begin
                        sreg_d       = word_bus.in_data;
                        sreg_valid_d = 1'b1;
                        bit_idx_d    = '0;
                    end else begin
                        sreg_valid_d = 1'b0;
                    end
                end else if (accept) begin
                    buf_d      = word_bus.in_data;
                    buf_full_d = 1'b1;
                end
                if ((state_q == StLoad) && accept) state_d = StShift;
                if (shifting && (cnt_q == LastShift)) begin
                    state_d      = StDone;
                    sreg_valid_d = 1'b0;
                    buf_full_d   = 1'b0;
                end
            end
            StCheck: begin
                shift_en = 1'b1;
                if (cnt_q == '0) ccff_head = '1;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q >= TailAt) begin
                    for (int unsigned c = 0; c < NUM_CHAINS; c++) begin
                        // Written positively so an X/Z tail falls into the error branch.
                        if (ccff_tail[c] == exp_tail) err_d[c] = err_q[c];
                        else err_d[c] = 1'b1;
                    end
                end
                if (cnt_q == LastCheck) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase

        if (abort) begin
            state_d      = StIdle;
            sreg_valid_d = 1'b0;
            buf_full_d   = 1'b0;
            cnt_d        = '0;
            bit_idx_d    = '0;
            err_d        = err_q;
        end
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_q      <= StIdle;
            sreg_q       <= '0;
            sreg_valid_q <= 1'b0;
            buf_q        <= '0;
            buf_full_q   <= 1'b0;
            bit_idx_q    <= '0;
            cnt_q        <= '0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            sreg_valid_q <= sreg_valid_d;
            buf_q        <= buf_d;
            buf_full_q   <= buf_full_d;
            bit_idx_q    <= bit_idx_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Randomized bench for ccff_chain_loader: two chains of 40 FFs fed 32-bit words,
// with a shift-register chain model driving ccff_tail.
module tb_ccff_chain_loader;
    localparam int unsigned NC = 2;
    localparam int unsigned CL = 40;
    localparam int unsigned WW = 32;
    localparam int unsigned CD = 3;

    logic prog_clk = 1'b0;
    logic pReset   = 1'b1;
    logic start    = 1'b0;
    logic mode     = 1'b0;
    logic abort    = 1'b0;
    logic [NC-1:0] ccff_head, ccff_tail, err_chain;
    logic shift_en, busy, done;

    int checks   = 0;
    int failures = 0;

    ccff_chain_loader_if #(.NUM_CHAINS(NC), .WORD_WIDTH(WW)) bus ();

    ccff_chain_loader #(
        .NUM_CHAINS  (NC),
        .CHAIN_LENGTH(CL),
        .WORD_WIDTH  (WW),
        .CHECK_DEPTH (CD)
    ) dut (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .start    (start),
        .mode     (mode),
        .abort    (abort),
        .word_bus (bus),
        .ccff_head(ccff_head),
        .ccff_tail(ccff_tail),
        .shift_en (shift_en),
        .busy     (busy),
        .done     (done),
        .err_chain(err_chain)
    );

    always #5 prog_clk = ~prog_clk;

    // Fabric model: each chain is a plain shift register of len[c] flops.
    logic [127:0]  ch [NC] = '{default: '0};
    int            len [NC] = '{CL, CL};
    logic          se_s = 1'b0;
    logic [NC-1:0] head_s = '0;

    always @(posedge prog_clk) begin
        if (se_s) for (int c = 0; c < NC; c++) ch[c] <= {ch[c][126:0], head_s[c]};
    end

    always_comb begin
        for (int c = 0; c < NC; c++) ccff_tail[c] = ch[c][len[c]-1];
    end

    // Output monitor, sampled mid-cycle.
    int mon_cyc = 0, mon_shifts = 0, mon_last = -1, mon_done = -1, mon_gap = 0, mon_head_bad = 0;
    logic [127:0] got [NC] = '{default: '0};

    always @(negedge prog_clk) begin
        mon_cyc++;
        if (shift_en) begin
            mon_shifts++;
            for (int c = 0; c < NC; c++) got[c] = {got[c][126:0], ccff_head[c]};
            if (mon_last >= 0) mon_gap += mon_cyc - mon_last - 1;
            mon_last = mon_cyc;
        end else if (ccff_head !== '0) begin
            mon_head_bad++;
        end
        if (done === 1'b1 && mon_done < 0) mon_done = mon_cyc;
        se_s   = shift_en;
        head_s = ccff_head;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        mon_shifts = 0; mon_last = -1; mon_done = -1; mon_gap = 0; mon_head_bad = 0;
        for (int c = 0; c < NC; c++) got[c] = '0;
    endtask

    task automatic cycle();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic do_start(input logic m);
        start = 1'b1;
        mode  = m;
        cycle();
        start = 1'b0;
        mode  = 1'b0;
    endtask

    task automatic send_word(input logic [NC*WW-1:0] d, input int gap, output bit ok);
        logic r;
        bus.in_valid = 1'b0;
        repeat (gap) cycle();
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge prog_clk);
            r = bus.in_ready;
            cycle();
            if (r) ok = 1'b1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        for (int i = 0; i < 400 && done !== 1'b1; i++) cycle();
        ok = (done === 1'b1);
    endtask

    task automatic wait_shifts(input int n);
        for (int i = 0; i < 200 && mon_shifts < n; i++) cycle();
    endtask

    // Expected head stream: chain c gets its slice of w0 then w1, MSB first, first CL bits only.
    function automatic logic [NC*CL-1:0] exp_stream(input logic [NC*WW-1:0] w0, w1);
        logic [2*WW-1:0] cat;
        logic [NC*CL-1:0] r;
        for (int c = 0; c < NC; c++) begin
            cat = {w0[c*WW +: WW], w1[c*WW +: WW]};
            r[c*CL +: CL] = cat[2*WW-1 -: CL];
        end
        return r;
    endfunction

    function automatic logic [NC*CL-1:0] got_stream();
        logic [NC*CL-1:0] r;
        for (int c = 0; c < NC; c++) r[c*CL +: CL] = got[c][CL-1:0];
        return r;
    endfunction

    function automatic logic [NC*(CL+CD)-1:0] got_check();
        logic [NC*(CL+CD)-1:0] r;
        for (int c = 0; c < NC; c++) r[c*(CL+CD) +: CL+CD] = got[c][CL+CD-1:0];
        return r;
    endfunction

    function automatic logic [NC*(CL+CD)-1:0] exp_check();
        logic [NC*(CL+CD)-1:0] r;
        logic [CL+CD-1:0] one;
        one = '0;
        one[CL+CD-1] = 1'b1;
        for (int c = 0; c < NC; c++) r[c*(CL+CD) +: CL+CD] = one;
        return r;
    endfunction

    task automatic test_reset();
        checks++;
        if ({shift_en, busy, done, bus.in_ready} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b need 0000", {shift_en, busy, done, bus.in_ready});
        end
        repeat (2) cycle();
        pReset = 1'b0;
        cycle();
        checks++;
        if (ccff_head !== '0) begin
            failures++;
            $display("FAIL reset_head: got %b need 00", ccff_head);
        end
        checks++;
        if (err_chain !== '0) begin
            failures++;
            $display("FAIL reset_err: got %b need 00", err_chain);
        end
        checks++;
        if ({shift_en, busy, done, bus.in_ready} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_idle: got %b need 0000", {shift_en, busy, done, bus.in_ready});
        end
    endtask

    task automatic test_back_to_back();
        logic [NC*WW-1:0] w0, w1;
        bit ok0, ok1, okd;
        for (int it = 0; it < 3; it++) begin
            w0 = {$urandom, $urandom};
            w1 = {$urandom, $urandom};
            do_start(1'b0);
            clear_mon();
            send_word(w0, 0, ok0);
            send_word(w1, 0, ok1);
            wait_done(okd);
            cycle();
            checks++;
            if ({ok0, ok1, okd} !== 3'b111) begin
                failures++;
                $display("FAIL b2b_handshake: accept/done %b need 111", {ok0, ok1, okd});
            end
            checks++;
            if (got_stream() !== exp_stream(w0, w1)) begin
                failures++;
                $display("FAIL b2b_stream: got %h need %h", got_stream(), exp_stream(w0, w1));
            end
            checks++;
            if (mon_shifts !== CL || mon_gap !== 0) begin
                failures++;
                $display("FAIL b2b_shifts: shifts %0d gap %0d need %0d/0", mon_shifts, mon_gap, CL);
            end
            checks++;
            if (mon_done !== mon_last + 1) begin
                failures++;
                $display("FAIL b2b_done_timing: done at %0d need %0d", mon_done, mon_last + 1);
            end
        end
    endtask

    task automatic test_stall();
        logic [NC*WW-1:0] w0, w1;
        bit ok0, ok1, okd;
        int w, exp_gap;
        for (int it = 0; it < 4; it++) begin
            w = (it == 0) ? 36 : int'($urandom_range(0, 45));
            // Word 2 is consumed one cycle after it is accepted once the shifter has run dry.
            exp_gap = (w > int'(WW) - 1) ? w - (int'(WW) - 1) : 0;
            w0 = {$urandom, $urandom};
            w1 = {$urandom, $urandom};
            do_start(1'b0);
            clear_mon();
            send_word(w0, 0, ok0);
            send_word(w1, w, ok1);
            wait_done(okd);
            cycle();
            checks++;
            if ({ok0, ok1, okd} !== 3'b111) begin
                failures++;
                $display("FAIL stall_handshake: accept/done %b need 111", {ok0, ok1, okd});
            end
            checks++;
            if (mon_gap !== exp_gap || mon_shifts !== CL) begin
                failures++;
                $display("FAIL stall_gap w=%0d: gap %0d shifts %0d need %0d/%0d",
                         w, mon_gap, mon_shifts, exp_gap, CL);
            end
            checks++;
            if (mon_head_bad !== 0) begin
                failures++;
                $display("FAIL stall_head: %0d idle cycles with head!=0 need 0", mon_head_bad);
            end
            checks++;
            if (got_stream() !== exp_stream(w0, w1)) begin
                failures++;
                $display("FAIL stall_stream: got %h need %h", got_stream(), exp_stream(w0, w1));
            end
        end
    endtask

    task automatic test_start_ignored();
        logic [NC*WW-1:0] w0, w1;
        bit ok0, ok1, okd;
        w0 = {$urandom, $urandom};
        w1 = {$urandom, $urandom};
        do_start(1'b0);
        clear_mon();
        send_word(w0, 0, ok0);
        start = 1'b1;
        mode  = 1'b1;
        cycle();
        start = 1'b0;
        mode  = 1'b0;
        send_word(w1, 0, ok1);
        wait_done(okd);
        cycle();
        checks++;
        if ({ok0, ok1, okd} !== 3'b111) begin
            failures++;
            $display("FAIL busy_start_handshake: accept/done %b need 111", {ok0, ok1, okd});
        end
        checks++;
        if (got_stream() !== exp_stream(w0, w1) || mon_shifts !== CL) begin
            failures++;
            $display("FAIL busy_start_stream: got %h (%0d shifts) need %h (%0d)",
                     got_stream(), mon_shifts, exp_stream(w0, w1), CL);
        end
    endtask

    task automatic test_check_pass();
        bit okd;
        len[0] = CL;
        len[1] = CL;
        do_start(1'b1);
        clear_mon();
        wait_done(okd);
        cycle();
        checks++;
        if (!okd || mon_shifts !== CL + CD) begin
            failures++;
            $display("FAIL check_pass_len: done %0b shifts %0d need 1/%0d", okd, mon_shifts, CL + CD);
        end
        checks++;
        if (got_check() !== exp_check()) begin
            failures++;
            $display("FAIL check_pass_head: got %h need %h", got_check(), exp_check());
        end
        checks++;
        if (err_chain !== 2'b00 || done !== 1'b1) begin
            failures++;
            $display("FAIL check_pass_err: err %b done %b need 00/1", err_chain, done);
        end
    endtask

    task automatic test_check_fail();
        bit okd;
        logic [NC-1:0] exp_err;
        for (int it = 0; it < 4; it++) begin
            for (int c = 0; c < NC; c++) len[c] = int'($urandom_range(CL - 2, CL + 2));
            if (it == 3) begin
                len[0] = CL;
                len[1] = CL - 1;
            end
            for (int c = 0; c < NC; c++) exp_err[c] = (len[c] != int'(CL));
            do_start(1'b1);
            clear_mon();
            wait_done(okd);
            cycle();
            checks++;
            if (!okd || err_chain !== exp_err) begin
                failures++;
                $display("FAIL check_err len=%0d/%0d: done %0b err %b need 1/%b",
                         len[0], len[1], okd, err_chain, exp_err);
            end
        end
        len[0] = CL;
        len[1] = CL;
    endtask

    task automatic test_abort();
        logic [NC*WW-1:0] w0, w1;
        bit ok0, ok1, okd;
        // From DONE after a failing CHECK: done drops, err_chain is kept.
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || err_chain !== 2'b10) begin
            failures++;
            $display("FAIL abort_done: done %b busy %b err %b need 0/0/10", done, busy, err_chain);
        end
        // Mid-SHIFT with a word waiting in the holding buffer.
        w0 = {$urandom, $urandom};
        w1 = {$urandom, $urandom};
        do_start(1'b0);
        clear_mon();
        send_word(w0, 0, ok0);
        bus.in_valid = 1'b1;
        bus.in_data  = w1;
        wait_shifts(10);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        checks++;
        if ({shift_en, bus.in_ready, done, busy} !== 4'b0000 || ccff_head !== '0) begin
            failures++;
            $display("FAIL abort_shift: se/rdy/done/busy %b head %b need 0000/00",
                     {shift_en, bus.in_ready, done, busy}, ccff_head);
        end
        repeat (3) cycle();
        checks++;
        if (shift_en !== 1'b0 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: shift_en %b in_ready %b need 0/0", shift_en, bus.in_ready);
        end
        bus.in_valid = 1'b0;
        w0 = {$urandom, $urandom};
        w1 = {$urandom, $urandom};
        do_start(1'b0);
        clear_mon();
        send_word(w0, 0, ok0);
        send_word(w1, 3, ok1);
        wait_done(okd);
        cycle();
        checks++;
        if (!(ok0 && ok1 && okd) || got_stream() !== exp_stream(w0, w1) || mon_shifts !== CL) begin
            failures++;
            $display("FAIL abort_rerun: got %h (%0d shifts) need %h (%0d)",
                     got_stream(), mon_shifts, exp_stream(w0, w1), CL);
        end
    endtask

    task automatic test_preset();
        logic [NC*WW-1:0] w0, w1;
        bit ok0, ok1, okd;
        w0 = {$urandom, $urandom};
        do_start(1'b0);
        clear_mon();
        send_word(w0, 0, ok0);
        wait_shifts(5);
        @(negedge prog_clk);
        pReset = 1'b1;
        #1;
        checks++;
        if ({shift_en, bus.in_ready, done, busy} !== 4'b0000 || err_chain !== '0) begin
            failures++;
            $display("FAIL preset_async: se/rdy/done/busy %b err %b need 0000/00",
                     {shift_en, bus.in_ready, done, busy}, err_chain);
        end
        cycle();
        pReset = 1'b0;
        cycle();
        w0 = {$urandom, $urandom};
        w1 = {$urandom, $urandom};
        do_start(1'b0);
        clear_mon();
        send_word(w0, 0, ok0);
        send_word(w1, 0, ok1);
        wait_done(okd);
        cycle();
        checks++;
        if (!(ok0 && ok1 && okd) || got_stream() !== exp_stream(w0, w1) || mon_shifts !== CL) begin
            failures++;
            $display("FAIL preset_rerun: got %h (%0d shifts) need %h (%0d)",
                     got_stream(), mon_shifts, exp_stream(w0, w1), CL);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        #1;
        test_reset();
        test_back_to_back();
        test_stall();
        test_start_ignored();
        test_check_pass();
        test_check_fail();
        test_abort();
        test_preset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
